// File: rtl/sar_conv_scheduler.sv
// Conversion scheduler for the 8-bit sar_logic ADC core: periodic or one-shot
// cnvst issue, eoc capture into a small result FIFO, and a per-conversion watchdog.
module sar_conv_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] period,
    input  logic        single,
    input  logic        clr,
    input  logic        eoc,
    input  logic [7:0]  sar,
    output logic        cnvst,
    output logic        busy,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        overflow,
    output logic        timeout_err,
    output logic [15:0] conv_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [15:0]   WD_LAST  = 16'(TIMEOUT - 1);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] ONE      = PW'(1);

    typedef enum logic [1:0] {IDLE, START, CONV, HOLD} state_t;

    state_t        state;
    logic [15:0]   ivl;
    logic [15:0]   wd;
    logic [15:0]   gap;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] count;
    logic          full;
    logic          pop;
    logic          hit;
    logic          expire;
    logic          push;
    logic          drop;

    assign gap        = (period == 16'd0) ? 16'd0 : period - 16'd1;
    assign full       = (count == FULL_CNT);
    assign dout_valid = (count != '0);
    assign pop        = dout_valid && dout_ready;
    assign hit        = (state == CONV) && eoc;
    // eoc in the last watchdog cycle still counts as a good conversion
    assign expire     = (state == CONV) && !eoc && (wd == WD_LAST);
    assign push       = hit && (!full || pop);
    assign drop       = hit && full && !pop;
    assign dout       = dout_valid ? mem[rptr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnvst <= 1'b0;
            busy  <= 1'b0;
            ivl   <= 16'd0;
            wd    <= 16'd0;
        end else begin
            cnvst <= 1'b0;
            if (ivl != 16'hFFFF) ivl <= ivl + 16'd1;
            if (wd != 16'hFFFF) wd <= wd + 16'd1;
            unique case (state)
                IDLE: begin
                    if (enable || single) begin
                        state <= START;
                        cnvst <= 1'b1;
                        busy  <= 1'b1;
                        ivl   <= 16'd0;
                        wd    <= 16'd0;
                    end
                end
                START: state <= CONV;
                CONV: begin
                    if (eoc || expire) begin
                        state <= HOLD;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (ivl >= gap) begin
                        state <= START;
                        cnvst <= 1'b1;
                        busy  <= 1'b1;
                        ivl   <= 16'd0;
                        wd    <= 16'd0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= sar;
    end

    // a set event in the same cycle as clr keeps the flag up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            conv_cnt    <= 16'd0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (push) begin
                wptr     <= wptr + ONE;
                conv_cnt <= conv_cnt + 16'd1;
            end
            if (pop) rptr <= rptr + ONE;
            if (push && !pop) count <= count + ONE;
            else if (pop && !push) count <= count - ONE;
            if (drop) overflow <= 1'b1;
            else if (clr) overflow <= 1'b0;
            if (expire) timeout_err <= 1'b1;
            else if (clr) timeout_err <= 1'b0;
        end
    end
endmodule

// File: doc/sar_conv_scheduler.md
# sar_conv_scheduler

Conversion scheduler for the 8-bit `sar_logic` ADC core. It issues `cnvst` pulses, either periodically or on a one-shot request, and waits for `eoc`. It captures the `sar` word into a small result FIFO that drains through a valid/ready port, and guards each conversion with a watchdog. It sits between the system control/readout logic and `sar_logic`, and shares that core's clock and reset.

## Interface
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: max cycles from `cnvst` to `eoc` before abort; 2..65535.
- `clk`  in  1  system clock; same clock as `sar_logic`.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  continuous (periodic) conversion mode.
- `period`  in  16  cycles between successive `cnvst` pulses in continuous mode; 0 treated as 1.
- `single`  in  1  one-shot request pulse; honoured only in IDLE.
- `clr`  in  1  clears the sticky error flags.
- `eoc`  in  1  end of conversion from `sar_logic`.
- `sar`  in  8  conversion result from `sar_logic`; valid while `eoc`=1.
- `cnvst`  out  1  one-cycle conversion start to `sar_logic`; registered.
- `busy`  out  1  high in START and CONV.
- `dout`  out  8  FIFO head word.
- `dout_valid`  out  1  FIFO not empty.
- `dout_ready`  in  1  consumer accepts `dout` when `dout_valid`&&`dout_ready`.
- `overflow`  out  1  sticky: a result was dropped because the FIFO was full.
- `timeout_err`  out  1  sticky: a conversion was aborted by the watchdog.
- `conv_cnt`  out  16  count of results written to the FIFO; wraps 0xFFFF→0.

## Operation
- State machine has four states: IDLE, START, CONV, HOLD.
  - IDLE→START when `enable`=1, or when `single`=1 and `enable`=0.
  - START→CONV unconditionally. `cnvst`=1 for exactly the START cycle. The interval counter `ivl` and the watchdog `wd` clear to 0.
  - CONV→HOLD on `eoc`=1. This writes `sar` to the FIFO.
  - CONV→HOLD also when `wd`==TIMEOUT-1 and `eoc`=0. This sets `timeout_err`; no FIFO write occurs.
  - HOLD→START when `enable`=1 and `ivl` ≥ max(`period`,1)-1.
  - HOLD→IDLE when `enable`=0.
- `ivl` counts every cycle after START and saturates at 0xFFFF. `period` is sampled live.
  - The next `cnvst` comes no earlier than `period` cycles after the previous one.
  - It also comes no earlier than 2 cycles after `eoc` (HOLD, then START). This allows `sar_logic` to re-enter its wait state.
- `single` arriving in any state other than IDLE is ignored, not queued.
- `eoc` outside CONV is ignored: no write, no state change.
- FIFO behaviour:
  - Write pointer, read pointer and count are `$clog2(DEPTH)+1` bits wide.
  - Pop occurs when `dout_valid`&&`dout_ready`.
  - Push when full and no pop: the word is dropped, `overflow` is set, and `conv_cnt` is unchanged.
  - Push when full with a simultaneous pop: the push is accepted and the count is unchanged.
  - Push when empty: `dout` and `dout_valid` update the next cycle; there is no combinational bypass.
  - `conv_cnt` increments only on an accepted push.
- Sticky flags: `clr` zeroes both flags. If a set event and `clr` occur in the same cycle, the set wins.
- A drop and a timeout cannot occur in the same conversion.

## Timing
- Reset (asynchronous, immediate) puts everything to 0:
  - state IDLE, `cnvst`=0, `busy`=0;
  - FIFO empty, `dout`=0x00, `dout_valid`=0;
  - `overflow`=0, `timeout_err`=0, `conv_cnt`=0, `ivl`=0, `wd`=0.
- Reset mid-conversion aborts with no FIFO write. `sar_logic` is reset by the same `rst`.
- Trigger latency: `enable` or `single` high in IDLE at edge N gives `cnvst`=1 in cycle N+1.
- Result latency: `eoc`=1 in cycle E gives `dout_valid`=1 and `dout`=`sar`(E) in cycle E+1 (when the FIFO was empty).
- Watchdog: with no `eoc`, `timeout_err` rises TIMEOUT cycles after the `cnvst` cycle. If `eoc` arrives in the same cycle as the timeout condition, `eoc` wins.
- Back-to-back conversions (`period`=0 or 1): `cnvst` is issued 2 cycles after each `eoc`.
- `busy` is registered with the state, so it is high in the same cycle as `cnvst`.

## Test plan
- `single` pulse with `enable`=0; model `eoc` 20 cycles after `cnvst` with `sar`=0xA5 → exactly one `cnvst`; `dout`=0xA5 with `dout_valid`=1 on the cycle after `eoc`; `conv_cnt`=1; state returns to IDLE.
- `enable`=1, `period`=50, `eoc` 20 cycles after each `cnvst` → `cnvst` spacing exactly 50 cycles. With `period`=0 → spacing = `eoc` delay + 2.
- `dout_ready`=0 with 6 conversions (DEPTH=4) → 4 words held in order, `overflow`=1, `conv_cnt`=4. Then drain with `dout_ready`=1 → first 4 values, in order.
- FIFO full with a push and pop in the same cycle → no drop, `overflow` stays 0, count stays 4.
- `eoc` never asserted, TIMEOUT=64 → `timeout_err`=1 64 cycles after `cnvst`, no FIFO write, next `cnvst` per period. `clr` clears the flag; `clr` coincident with a new timeout leaves the flag at 1.
- `rst` asserted mid-CONV → outputs go to their reset values immediately. After release, an `eoc` arriving while IDLE is ignored (`dout_valid` stays 0).
